// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: FSM states and default
// address width / vector addresses.
package pc_pkg;

  typedef enum logic {
    PC_OFF = 1'b0,
    PC_RUN = 1'b1
  } pc_state_t;

  localparam int          PC_ADDR_W    = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-branch holder: a branch seen under stall is parked here
// until the PC can take it; a newer capture overwrites, consume/clear empty it.
module pc_redirect_buf #(
  parameter int ADDR_W = pc_pkg::PC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              consume_i,
  input  logic              clear_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] target_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_o    <= 1'b0;
      target_o <= '0;
    end else if (clear_i || consume_i) begin
      // A flush outranks a branch captured in the same cycle.
      vld_o <= 1'b0;
    end else if (capture_i) begin
      vld_o    <= 1'b1;
      target_o <= target_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: OFF/RUN sequencer with flush > branch > stall > sequential
// priority. PC_ALIGN_CHECK_EN traps misaligned redirects to EXC_VEC.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = PC_ADDR_W,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(PC_EXC_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  input  logic              if_gnt_i,
  output logic              ce_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              misalign_o
);

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(INST_BYTES);

  pc_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misalign_q, misalign_d;

  logic              redir_vld;
  logic [ADDR_W-1:0] redir_tgt;
  logic              pend_capture;
  logic              pend_consume;
  logic              pend_clear;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_tgt;

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .capture_i (pend_capture),
    .target_i  (branch_target_i),
    .consume_i (pend_consume),
    .clear_i   (pend_clear),
    .vld_o     (pend_vld),
    .target_o  (pend_tgt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PC_OFF;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    misalign_d   = 1'b0;
    redir_vld    = 1'b0;
    redir_tgt    = '0;
    pend_capture = 1'b0;
    pend_consume = 1'b0;
    pend_clear   = 1'b0;

    case (state_q)
      PC_OFF: begin
        // First fetch is RESET_VEC itself, so the PC is not advanced here.
        state_d = PC_RUN;
        pc_d    = RESET_VEC;
      end
      PC_RUN: begin
        if (flush_i) begin
          redir_vld  = 1'b1;
          redir_tgt  = flush_target_i;
          pend_clear = 1'b1;
        end else if (branch_i && !stall_i) begin
          // A fresh branch supersedes anything still parked.
          redir_vld  = 1'b1;
          redir_tgt  = branch_target_i;
          pend_clear = 1'b1;
        end else if (pend_vld && !stall_i && if_gnt_i) begin
          redir_vld    = 1'b1;
          redir_tgt    = pend_tgt;
          pend_consume = 1'b1;
        end else if (branch_i) begin
          pend_capture = 1'b1;
        end else if (!stall_i && if_gnt_i) begin
          pc_d = pc_q + PC_INC;
        end
      end
      default: begin
        state_d = PC_OFF;
        pc_d    = RESET_VEC;
      end
    endcase

    if (redir_vld) begin
      if (ALIGN_CHECK && |(redir_tgt & LOW_MASK)) begin
        pc_d       = EXC_VEC;
        misalign_d = 1'b1;
      end else begin
        pc_d = redir_tgt & ~LOW_MASK;
      end
    end
  end

  assign ce_o       = (state_q == PC_RUN);
  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them.
module tb_pc_gen;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target_i = '0;
  logic        if_gnt_i = 1'b0;
  logic        ce_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .flush_target_i  (flush_target_i),
    .if_gnt_i        (if_gnt_i),
    .ce_o            (ce_o),
    .pc_o            (pc_o),
    .misalign_o      (misalign_o)
  );

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input logic r, input logic st, input logic gnt,
                      input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] ft,
                      input logic ece, input logic [31:0] epc, input logic emis);
    exp_t e;
    rst = r; stall_i = st; if_gnt_i = gnt;
    branch_i = br; branch_target_i = bt;
    flush_i = fl; flush_target_i = ft;
    @(posedge clk);
    e.ce = ece; e.pc = epc; e.mis = emis;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vec++;
        checks += 3;
        if (ce_o !== e.ce) begin
          errors++;
          $display("FAIL ce v%0d: got %b expected %b", vec, ce_o, e.ce);
        end
        if (pc_o !== e.pc) begin
          errors++;
          $display("FAIL pc v%0d: got %h expected %h", vec, pc_o, e.pc);
        end
        if (misalign_o !== e.mis) begin
          errors++;
          $display("FAIL misalign v%0d: got %b expected %b", vec, misalign_o, e.mis);
        end
      end
    end
  end

  initial begin : stim
    //   rst st gnt br bt            fl ft            ce pc             mis
    // Reset held 3 cycles, then release: 0x0, 0x4, 0x8 ...
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    step(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0);
    // Branch during 2-cycle stall at 0x10.
    step(0, 1, 1, 1, 32'h200,      0, 32'h0,        1, 32'h10,       0);
    step(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h10,       0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h200,      0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h204,      0);
    // Flush and stalled branch together: flush wins, branch dropped.
    step(0, 1, 1, 1, 32'h300,      1, 32'h40,       1, 32'h40,       0);
    step(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h40,       0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h44,       0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h48,       0);
    // Grant withheld at 0x20.
    step(0, 0, 1, 1, 32'h20,       0, 32'h0,        1, 32'h20,       0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h20,       0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h24,       0);
    // Wrap at top of address space.
    step(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,       1, 32'hFFFF_FFFC, 0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
    // Pending overwrite; applied only once unstalled and granted.
    step(0, 1, 1, 1, 32'h500,      0, 32'h0,        1, 32'h0,        0);
    step(0, 1, 1, 1, 32'h600,      0, 32'h0,        1, 32'h0,        0);
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h600,      0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h604,      0);
    // Misaligned branch and flush targets.
    step(0, 0, 1, 1, 32'h102,      0, 32'h0,        1, CHK ? 32'h80 : 32'h100, CHK);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, CHK ? 32'h84 : 32'h104, 0);
    step(0, 1, 1, 0, 32'h0,        1, 32'h43,       1, CHK ? 32'h80 : 32'h40,  CHK);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, CHK ? 32'h84 : 32'h44,  0);
    // Reset mid-operation discards a pending branch; OFF ignores redirects.
    step(0, 1, 1, 1, 32'h700,      0, 32'h0,        1, CHK ? 32'h84 : 32'h44,  0);
    step(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0);
    step(0, 1, 1, 1, 32'h900,      1, 32'hA00,      1, 32'h0,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0);
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h8,        0);
    done = 1'b1;
  end

  initial begin : finisher
    int budget;
    budget = 0;
    while (!done && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (!done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", done, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/address width in bits.
REQ-002 SHALL have parameter INST_BYTES, default 4, byte increment per sequential fetch (power of two).
REQ-003 SHALL have parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-004 SHALL have parameter EXC_VEC, default 32'h0000_0080, redirect address on misalignment fault.
REQ-005 SHALL have clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have stall_i  in  1  pipeline stall request from control.
REQ-008 SHALL have branch_i  in  1  taken branch/jump, one-cycle pulse.
REQ-009 SHALL have branch_target_i  in  ADDR_W  branch destination.
REQ-010 SHALL have flush_i  in  1  exception/flush redirect, one-cycle pulse.
REQ-011 SHALL have flush_target_i  in  ADDR_W  flush destination.
REQ-012 SHALL have if_gnt_i  in  1  instruction memory accepted current request.
REQ-013 SHALL have ce_o  out  1  fetch enable to ROM and IF/ID.
REQ-014 SHALL have pc_o  out  ADDR_W  current fetch address (also the ROM address).
REQ-015 SHALL have misalign_o  out  1  one-cycle fault pulse (tied 0 when the check is compiled out).

Function
REQ-016 SHALL implement states OFF (ce_o=0) and RUN (ce_o=1); OFF->RUN on the first clock edge with rst=0, RUN->OFF on any edge with rst=1.
REQ-017 SHALL present pc_o=RESET_VEC on the first RUN cycle; the first fetch is RESET_VEC, not RESET_VEC+INST_BYTES.
REQ-018 SHALL update pc in RUN with priority flush_i > pending/branch > stall_i > sequential.
REQ-019 SHALL load flush_target_i into pc on the next edge when flush_i=1, regardless of stall_i or if_gnt_i, and clear any pending branch.
REQ-020 SHALL load branch_target_i into pc on the next edge when branch_i=1, stall_i=0 and flush_i=0.
REQ-021 SHALL capture branch_i with stall_i=1 into a single pending register (valid+target); a later branch overwrites it; it is applied on the first edge with stall_i=0, if_gnt_i=1 and flush_i=0, then cleared.
REQ-022 SHALL advance pc by INST_BYTES only when stall_i=0, if_gnt_i=1 and no redirect; otherwise pc holds.
REQ-023 SHALL wrap pc modulo 2^ADDR_W (all-ones minus INST_BYTES-1, plus INST_BYTES, gives 0); no overflow flag.
REQ-024 SHALL ignore branch_i, flush_i and stall_i in OFF.

Reset
REQ-025 SHALL, on any edge with rst=1, set state=OFF, ce_o=0, pc_o=RESET_VEC, pending valid=0, misalign_o=0; reset mid-operation discards any pending redirect.

Configuration
REQ-026 SHALL, with PC_ALIGN_CHECK_EN defined, check each redirect target for nonzero low log2(INST_BYTES) bits; on a misaligned target, load EXC_VEC instead and pulse misalign_o for one cycle.
REQ-027 SHALL, without PC_ALIGN_CHECK_EN, force the low log2(INST_BYTES) bits of every redirect target to zero and tie misalign_o to 0.

Structure
REQ-028 SHALL take the state enum, default ADDR_W, RESET_VEC and EXC_VEC from shared package pc_pkg.
REQ-029 SHALL implement the pending-branch register as sub-module pc_redirect_buf (capture, overwrite, consume, clear).

Verification (ADDR_W=32, INST_BYTES=4, RESET_VEC=0, EXC_VEC=0x80)
REQ-030 SHALL cover: rst high 3 cycles, then low, if_gnt_i=1 -> ce_o 0 until the first edge after release, then pc_o 0x0,0x4,0x8 on consecutive cycles.
REQ-031 SHALL cover: stall_i=1 for 2 cycles at pc 0x10 with branch_i pulse to 0x200 during the stall -> pc_o holds 0x10, then 0x200, then 0x204.
REQ-032 SHALL cover: flush_i to 0x40 and branch_i to 0x300 in the same cycle with stall_i=1 -> next pc_o 0x40, pending cleared, 0x300 never fetched.
REQ-033 SHALL cover: if_gnt_i=0 for 3 cycles at pc 0x20 -> pc_o holds 0x20; then if_gnt_i=1 -> 0x24.
REQ-034 SHALL cover: pc 0xFFFF_FFFC with if_gnt_i=1 -> next pc_o 0x0000_0000.
REQ-035 SHALL cover: branch to 0x102 -> with PC_ALIGN_CHECK_EN, pc_o 0x80 and a one-cycle misalign_o; without it, pc_o 0x100 and misalign_o 0.
